// File: rtl/skew_sequencer.sv
// Operand sequencer for an NxN output-stationary systolic array: skews A rows and
// B columns diagonally and drives the array's clear/compute/drain/precision controls.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module skew_sequencer #(
    parameter int N          = 4,
    parameter int K_MAX      = 16,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int KW         = $clog2(K_MAX + 1)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic                                         abort,
    input  logic [KW-1:0]                                k_len,
    input  logic [1:0]                                   mode_in,
    input  logic [N-1:0][K_MAX-1:0][DATA_WIDTH-1:0]      a_mat,
    input  logic [K_MAX-1:0][N-1:0][DATA_WIDTH-1:0]      b_mat,
    output logic                                         busy,
    output logic                                         done,
    output logic [N-1:0][DATA_WIDTH-1:0]                 input_data,
    output logic [N-1:0][DATA_WIDTH-1:0]                 weight_data,
    output logic [1:0]                                   precision_mode,
    output logic                                         compute_enable,
    output logic                                         drain_enable,
    output logic                                         acc_clear
);

    // Counter must hold k_eff+2N-3 (FEED) and N-1 (DRAIN) without wrapping.
    localparam int CW = $clog2(K_MAX + 2 * N);
    localparam int IW = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   k_eff_q, k_eff_d;
    logic [1:0]      mode_q, mode_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ce_q, ce_d;
    logic            de_q, de_d;
    logic            clr_q, clr_d;
    logic [CW-1:0]   feed_last;
    logic [CW-1:0]   idx;

    assign feed_last = CW'(k_eff_q) + CW'(2 * N - 3);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_eff_d = k_eff_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    k_eff_d = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
                    mode_d  = mode_in;
                end
            end
            S_CLEAR: begin
                state_d = (k_eff_q != '0) ? S_FEED : S_DRAIN;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == feed_last) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every transition and clears the latched context.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            k_eff_d = '0;
            mode_d  = '0;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        ce_d   = (state_d == S_FEED);
        de_d   = (state_d == S_DRAIN);
        clr_d  = (state_d == S_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_eff_q <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ce_q    <= 1'b0;
            de_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_eff_q <= k_eff_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ce_q    <= ce_d;
            de_q    <= de_d;
            clr_q   <= clr_d;
        end
    end

    // Lane i sees element t-i; idx < k_eff <= K_MAX so the narrowed index is exact.
    always_comb begin
        input_data  = '0;
        weight_data = '0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            if (state_q == S_FEED && cnt_q >= CW'(i)) begin
                idx = cnt_q - CW'(i);
                if (idx < CW'(k_eff_q)) begin
                    input_data[i]  = a_mat[i][idx[IW-1:0]];
                    weight_data[i] = b_mat[idx[IW-1:0]][i];
                end
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign compute_enable = ce_q;
    assign drain_enable   = de_q;
    assign acc_clear      = clr_q;
    assign precision_mode = mode_q;

endmodule

// File: doc/skew_sequencer.md
Name: skew_sequencer

Overview:
- Parametrised operand sequencer for the NxN output-stationary `systolic_array`.
- Replaces the fixed 4x4 skewer and its hard-tied array controls.
- Takes an A tile (N rows x K_MAX) and a B tile (K_MAX x N cols) with a runtime reduction length k_len. Emits the diagonally skewed input/weight streams and drives acc_clear, compute_enable, drain_enable and precision_mode itself.
- Uses a start/busy/done handshake plus a synchronous abort.

Parameters:
- N, 4, array dimension: rows of A, columns of B, and skew lanes.
- K_MAX, 16, maximum reduction length supported.
- DATA_WIDTH, `DATA_WIDTH, element width.
- KW, $clog2(K_MAX+1), width of k_len.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a tile; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE with no done.
- k_len  input  KW  reduction length; latched at start.
- mode_in  input  2  precision mode; latched at start.
- a_mat  input  [N-1:0][K_MAX-1:0] x DATA_WIDTH  A operand; caller holds it stable while busy.
- b_mat  input  [K_MAX-1:0][N-1:0] x DATA_WIDTH  B operand; caller holds it stable while busy.
- busy  output  1  high from the cycle after start is accepted until the cycle after done.
- done  output  1  one-cycle pulse at completion.
- input_data  output  [N-1:0] x DATA_WIDTH  skewed row stream to the array.
- weight_data  output  [N-1:0] x DATA_WIDTH  skewed column stream to the array.
- precision_mode  output  2  latched mode_in.
- compute_enable  output  1  high only in FEED.
- drain_enable  output  1  high only in DRAIN.
- acc_clear  output  1  high only in CLEAR.

Behaviour:
- Reset values: all outputs 0, all data lanes 0, state IDLE, counter 0, latched k_len 0, latched mode 0.
- All outputs are decoded from registered state/counter and latched values. The only combinational path is a_mat/b_mat through the operand muxes.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 latches k_eff = min(k_len, K_MAX) and mode_in, then moves to CLEAR.
  - busy is 0 and data lanes are 0.
- CLEAR: exactly 1 cycle, acc_clear=1. Next state is FEED if k_eff>0, else DRAIN.
- FEED:
  - Counter t runs 0 .. k_eff+2N-3, i.e. k_eff+2N-2 cycles, with compute_enable=1.
  - input_data[r] = a_mat[r][t-r] when 0 <= t-r < k_eff, else 0.
  - weight_data[c] = b_mat[t-c][c] when 0 <= t-c < k_eff, else 0.
  - The trailing 2N-2-ish zero cycles flush the last products to PE(N-1,N-1).
- DRAIN: exactly N cycles, drain_enable=1, data lanes 0, counter reset on entry.
- DONE: 1 cycle, done=1, busy=1, all enables 0, then IDLE. busy=0 in the following cycle.
- Latency: start accepted at edge E means CLEAR is cycle E+1. done is high in cycle E+1+1+(k_eff+2N-2)+N when k_eff>0, and in cycle E+2+N when k_eff=0.
- start while not IDLE is ignored and does not queue.
- start and done coincide: start is ignored, since the state is DONE, not IDLE.
- abort=1 in any non-IDLE state: next cycle is IDLE, all outputs 0, no done pulse. Abort takes priority over every transition. abort in IDLE has no effect; abort and start together in IDLE means abort wins, so nothing starts.
- k_len > K_MAX clamps to K_MAX. k_len changes after start have no effect.
- Asynchronous reset mid-operation immediately forces reset values. No done is produced.
- The counter is wide enough for K_MAX+2N-2 with no wrap. The operand index mux never addresses beyond k_eff-1.

Test Plan:
- N=4, k_len=4, A=B=identity, start pulse at cycle 0 -> acc_clear at cycle 1, compute_enable cycles 2-11, drain_enable cycles 12-15, done at cycle 16, busy 0 at cycle 17. Array result = identity.
- N=4, k_len=4, A[r][k]=r*4+k+1, B[k][c]=k*4+c+1 -> at FEED t=3, input_data = {4,7,10,13} (lanes 0..3) and weight_data = {13,10,7,4}. Drained C matches the reference matmul, e.g. C[0][0]=90.
- k_len=0 -> CLEAR then DRAIN only, no compute_enable. done 6 cycles after the start edge.
- k_len=31, K_MAX=16 -> behaves as k_eff=16 with FEED length 22. start re-pulsed mid-FEED is ignored and the run is unchanged.
- abort asserted at FEED t=5 -> IDLE next cycle, all lanes 0, done never pulses. A following start runs normally from CLEAR.
- rst_n dropped asynchronously during DRAIN -> outputs 0 within the same cycle. After release, IDLE with busy=0 and no spurious done.
